// File: rtl/tx_fifo_arbiter_if.sv
// Bundle of the requester handshake, FIFO write port and status signals of
// tx_fifo_arbiter. The arbiter connects through the master modport. The
// requesters, FIFO and status consumer connect through the slave modport.
interface tx_fifo_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_full;
    logic                          fifo_wr_ena;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_last;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          frame_done;
    logic [NUM_REQ-1:0]            err_overlen;
    logic                          err_clr;

    modport master (
        input  req_valid, req_data, req_last, fifo_wr_full, err_clr,
        output req_ready, fifo_wr_ena, fifo_wr_data, fifo_wr_last,
               grant, busy, frame_done, err_overlen
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_wr_full, err_clr,
        input  req_ready, fifo_wr_ena, fifo_wr_data, fifo_wr_last,
               grant, busy, frame_done, err_overlen
    );
endinterface

// File: rtl/tx_fifo_arbiter.sv
// Frame-granular round-robin arbiter in front of the TX FIFO write port.
// A grant is held from the first word to the last word of a frame, so frames
// never interleave in the FIFO. Frames longer than MAX_FRAME_WORDS are cut:
// the word at the limit is written with LAST set, the owner's sticky overlength
// flag is raised, and the rest of the frame is swallowed.
module tx_fifo_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_FRAME_WORDS = 384
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tx_fifo_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_FRAME_WORDS > 1) ? $clog2(MAX_FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FRAME_WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic [NUM_REQ-1:0]    grant_q,      grant_d;
    logic [IDX_W-1:0]      owner_q,      owner_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      count_q,      count_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_REQ-1:0]    err_q,        err_d;

    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  at_max;
    logic                  xfer_acc;
    logic                  drop_acc;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      cand;

    assign own_valid = bus.req_valid[owner_q];
    assign own_last  = bus.req_last[owner_q];
    assign at_max    = (count_q == CNT_LAST);
    assign xfer_acc  = (state_q == ST_XFER) && own_valid && !bus.fifo_wr_full;
    assign drop_acc  = (state_q == ST_DROP) && own_valid;

    // Select the current owner's data word from the packed requester bus.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pick: first valid requester after the previous owner, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!pick_valid && bus.req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Zero-latency write path and ready steering; everything is quiet in IDLE.
    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_wr_ena  = 1'b0;
        bus.fifo_wr_data = '0;
        bus.fifo_wr_last = 1'b0;
        case (state_q)
            ST_XFER: begin
                bus.req_ready[owner_q] = !bus.fifo_wr_full;
                bus.fifo_wr_ena        = own_valid && !bus.fifo_wr_full;
                bus.fifo_wr_data       = own_data;
                bus.fifo_wr_last       = own_last || at_max;
            end
            ST_DROP: bus.req_ready[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.frame_done  = frame_done_q;
    assign bus.err_overlen = err_q;

    // Next-state logic: arbitration, frame word counting, truncation and error flags.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        frame_done_d = 1'b0;
        // Clear is applied first so a same-cycle overlength set wins.
        err_d        = bus.err_clr ? '0 : err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_XFER;
                    owner_d = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    count_d = '0;
                end
            end
            ST_XFER: begin
                if (xfer_acc) begin
                    if (own_last) begin
                        frame_done_d = 1'b1;
                        last_grant_d = owner_q;
                        count_d      = '0;
                        grant_d      = '0;
                        state_d      = ST_IDLE;
                    end else if (at_max) begin
                        frame_done_d   = 1'b1;
                        err_d[owner_q] = 1'b1;
                        count_d        = '0;
                        state_d        = ST_DROP;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (drop_acc && own_last) begin
                    last_grant_d = owner_q;
                    grant_d      = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; requester 0 wins the first arbitration.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            count_q      <= '0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end
endmodule
